// File: rtl/alu_controlador_if.sv
// Request/response bundle between the instruction side, the ALU controller
// and the external registered ALU.
interface alu_controlador_if;
  // request side
  logic        valido_in;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] operando_a;
  logic [31:0] operando_b;
  // ALU return path
  logic [31:0] saida;
  // controller outputs
  logic [3:0]  ALUcontrol;
  logic [31:0] entrada1;
  logic [31:0] entrada2;
  logic        pronto;
  logic [31:0] resultado;
  logic        resultado_valido;
  logic        desvio;
  logic        zero_out;
  logic        erro;

  // controller side
  modport slave (
    input  valido_in, ALUOp, funct3, funct7_5, operando_a, operando_b, saida,
    output ALUcontrol, entrada1, entrada2, pronto, resultado,
           resultado_valido, desvio, zero_out, erro
  );

  // requester / ALU side
  modport master (
    output valido_in, ALUOp, funct3, funct7_5, operando_a, operando_b, saida,
    input  ALUcontrol, entrada1, entrada2, pronto, resultado,
           resultado_valido, desvio, zero_out, erro
  );
endinterface

// File: rtl/alu_controlador.sv
// ALU controller: decodes ALUOp/funct fields into an ALU opcode, drives the
// operands to an external registered ALU, captures its result two edges
// after accept and resolves BEQ/BNE from the 32-bit zero test.
module alu_controlador (
  input  logic               clock,
  input  logic               reset,
  alu_controlador_if.slave   bus
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;

  typedef enum logic [2:0] {OCIOSO, EMITE, ESPERA, CONCLUI, ERRO} state_t;
  typedef enum logic [1:0] {BR_NONE, BR_BEQ, BR_BNE} br_t;

  state_t      state_q, state_d;
  br_t         br_q, br_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [31:0] e1_q, e1_d;
  logic [31:0] e2_q, e2_d;
  logic [31:0] res_q, res_d;
  logic        desvio_q, desvio_d;
  logic        zero_q, zero_d;

  logic        dec_ok;
  logic [3:0]  dec_ctl;
  br_t         dec_br;
  logic        accept;
  logic        saida_zero;

  assign accept     = bus.valido_in && (state_q == OCIOSO);
  assign saida_zero = (bus.saida == 32'd0);

  // Instruction decode: opcode, branch kind and legality of the encoding
  always_comb begin
    dec_ok  = 1'b1;
    dec_ctl = CTL_ADD;
    dec_br  = BR_NONE;
    case (bus.ALUOp)
      2'b00: dec_ctl = CTL_ADD;
      2'b01: begin
        dec_ctl = CTL_SUB;
        case (bus.funct3)
          3'b000:  dec_br = BR_BEQ;
          3'b001:  dec_br = BR_BNE;
          default: dec_ok = 1'b0;
        endcase
      end
      2'b10: begin
        case ({bus.funct7_5, bus.funct3})
          4'b0_000: dec_ctl = CTL_ADD;
          4'b1_000: dec_ctl = CTL_SUB;
          4'b0_111: dec_ctl = CTL_AND;
          4'b0_110: dec_ctl = CTL_OR;
          default:  dec_ok  = 1'b0;
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Next state and datapath updates; operands only load on a legal accept
  always_comb begin
    state_d  = state_q;
    br_d     = br_q;
    ctl_d    = ctl_q;
    e1_d     = e1_q;
    e2_d     = e2_q;
    res_d    = res_q;
    desvio_d = desvio_q;
    zero_d   = zero_q;
    case (state_q)
      OCIOSO: begin
        if (accept) begin
          if (dec_ok) begin
            state_d = EMITE;
            ctl_d   = dec_ctl;
            br_d    = dec_br;
            e1_d    = bus.operando_a;
            e2_d    = bus.operando_b;
          end else begin
            state_d = ERRO;
          end
        end
      end
      EMITE:  state_d = ESPERA;
      ESPERA: begin
        state_d = CONCLUI;
        res_d   = bus.saida;
        zero_d  = saida_zero;
        case (br_q)
          BR_BEQ:  desvio_d = saida_zero;
          BR_BNE:  desvio_d = !saida_zero;
          default: desvio_d = 1'b0;
        endcase
      end
      CONCLUI: state_d = OCIOSO;
      ERRO:    state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= OCIOSO;
      br_q     <= BR_NONE;
      ctl_q    <= 4'b0000;
      e1_q     <= 32'd0;
      e2_q     <= 32'd0;
      res_q    <= 32'd0;
      desvio_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      br_q     <= br_d;
      ctl_q    <= ctl_d;
      e1_q     <= e1_d;
      e2_q     <= e2_d;
      res_q    <= res_d;
      desvio_q <= desvio_d;
      zero_q   <= zero_d;
    end
  end

  // Status strobes are state decodes, so reset clears them immediately
  assign bus.pronto           = (state_q == OCIOSO);
  assign bus.resultado_valido = (state_q == CONCLUI);
  assign bus.erro             = (state_q == ERRO);
  assign bus.ALUcontrol       = ctl_q;
  assign bus.entrada1         = e1_q;
  assign bus.entrada2         = e2_q;
  assign bus.resultado        = res_q;
  assign bus.desvio           = desvio_q;
  assign bus.zero_out         = zero_q;

endmodule
